pri_dec_mask: RTL

- Registered binary-index-to-one-hot decoder: the decode-direction counterpart of the pri_enc priority encoder.
- Holds a sticky occupancy mask. Per cycle, one index may set its mask bit and one index may clear its mask bit.
- Tracks occupancy count and full/empty flags.
- Used as a valid-bit/allocation table whose mask output feeds pri_enc to pick the next entry.

---
 rtl/pri_dec_mask_if.sv | 38 +++
 rtl/pri_dec_mask.sv | 76 +++++++
 2 files changed

// File: rtl/pri_dec_mask_if.sv
// Request/status bundle for pri_dec_mask; err exists only when PRI_DEC_ERR_EN is defined.
interface pri_dec_mask_if #(
   parameter int IN  = 4,
   parameter int OUT = 1 << IN
);
   logic            set_valid;
   logic [IN-1:0]   set_idx;
   logic            clr_valid;
   logic [IN-1:0]   clr_idx;
   logic            flush;
   logic            valid;
   logic [OUT-1:0]  out_onehot;
   logic [OUT-1:0]  mask;
   logic [IN:0]     cnt;
   logic            full;
   logic            empty;
`ifdef PRI_DEC_ERR_EN
   logic            err;
`endif

   modport master (
      output set_valid, set_idx, clr_valid, clr_idx, flush,
      input  valid, out_onehot, mask, cnt, full
      , input empty
`ifdef PRI_DEC_ERR_EN
      , input err
`endif
   );

   modport slave (
      input  set_valid, set_idx, clr_valid, clr_idx, flush,
      output valid, out_onehot, mask, cnt, full
      , output empty
`ifdef PRI_DEC_ERR_EN
      , output err
`endif
   );
endinterface

// File: rtl/pri_dec_mask.sv
// Registered index-to-one-hot decoder with sticky occupancy mask and count; 1-cycle latency,
// no backpressure (every request accepted). Optional sticky err output via PRI_DEC_ERR_EN.
module pri_dec_mask #(
   parameter int IN  = 4,
   parameter int OUT = 1 << IN,
   parameter bit ACT = 1'b1          // 1: set bits read 1, 0: set bits read 0
) (
   input  logic            clk,
   input  logic            reset,
   pri_dec_mask_if.slave   bus
);
   localparam logic [OUT-1:0] ONE     = {{(OUT-1){1'b0}}, 1'b1};
   localparam logic [IN:0]    CNT_ONE = {{IN{1'b0}}, 1'b1};
   localparam logic [IN:0]    CNT_MAX = (IN+1)'(OUT);

   logic [OUT-1:0] mask_q, onehot_q;
   logic           valid_q;
   logic [IN:0]    cnt_q;

   logic [OUT-1:0] mask_flushed, set_vec, clr_vec, mask_d;
   logic           same_idx, cnt_inc, cnt_dec;
   logic [IN:0]    cnt_d;

   always_comb begin
      mask_flushed = bus.flush ? '0 : mask_q;
      set_vec      = bus.set_valid ? (ONE << bus.set_idx) : '0;
      clr_vec      = bus.clr_valid ? (ONE << bus.clr_idx) : '0;
      mask_d       = (mask_flushed & ~clr_vec) | set_vec;
      same_idx     = bus.set_valid && bus.clr_valid && (bus.set_idx == bus.clr_idx);
      // A clear cancelled by a same-index set neither frees nor re-occupies the bit.
      cnt_inc      = bus.set_valid && !mask_flushed[bus.set_idx];
      cnt_dec      = bus.clr_valid && mask_flushed[bus.clr_idx] && !same_idx;
      cnt_d        = bus.flush ? '0 : cnt_q;
      if (cnt_inc) cnt_d = cnt_d + CNT_ONE;
      if (cnt_dec) cnt_d = cnt_d - CNT_ONE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q   <= '0;
         onehot_q <= '0;
         valid_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         mask_q   <= mask_d;
         onehot_q <= set_vec;
         valid_q  <= bus.set_valid;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.mask       = ACT ? mask_q   : ~mask_q;
   assign bus.out_onehot = ACT ? onehot_q : ~onehot_q;
   assign bus.valid      = valid_q;
   assign bus.cnt        = cnt_q;
   assign bus.full       = (cnt_q == CNT_MAX);
   assign bus.empty      = (cnt_q == '0);

`ifdef PRI_DEC_ERR_EN
   logic err_q, err_hit;

   always_comb begin
      err_hit = !bus.flush &&
                ((bus.set_valid && mask_q[bus.set_idx] && !same_idx) ||
                 (bus.clr_valid && !mask_q[bus.clr_idx] && !same_idx));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)          err_q <= 1'b0;
      else if (bus.flush) err_q <= 1'b0;
      else if (err_hit)   err_q <= 1'b1;
   end

   assign bus.err = err_q;
`endif
endmodule
